bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter.
- Sits directly upstream of the 4-digit seven-segment multiplexer.
- Converts a binary value (e.g. PWM duty count or measured frequency) into four BCD digits that drive the multiplexer's hex3..hex0 inputs.
- Uses a start/done handshake; outputs hold the last result so the display never flickers mid-conversion.

Parameters:
- W, 14, width of binary input; legal range 4..14.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request conversion; sampled only in IDLE
- bin  input  W  binary value; sampled on the edge that accepts start
- ready  output  1  high in IDLE (can accept start)
- done_tick  output  1  one-cycle pulse when new result is on outputs
- ovf  output  1  registered; 1 if last converted value > 9999
- bcd3  output  4  thousands digit
- bcd2  output  4  hundreds digit
- bcd1  output  4  tens digit
- bcd0  output  4  units digit

Behaviour:
- Reset (async, active-high): state=IDLE, ready=1, done_tick=0, ovf=0, bcd3..bcd0=0, internal shift/BCD/iteration registers=0. Reset asserted mid-conversion aborts it immediately; outputs return to 0.
- Internal working registers:
  - 5 BCD digits (d4..d0, 20 bits), so any W<=14 value (max 16383) is represented exactly.
  - W-bit shift register.
  - Iteration counter of ceil(log2(W+1)) bits.
- FSM states: IDLE, OP, DONE.
  - IDLE: ready=1. On an edge with start=1: latch bin into the shift register, clear d4..d0, load counter=W, go to OP. With start=0, stay in IDLE.
  - OP: ready=0. Each edge performs one iteration:
    - Each working digit >=5 gets +3 (combinational, computed from current digits).
    - The {d4..d0, shift} concatenation shifts left by one; shift MSB enters d0 LSB.
    - Counter decrements. When counter reaches 1 on the current edge (i.e. this edge is the W-th iteration), go to DONE.
  - DONE: on the next edge, register outputs and pulse.
    - If d4!=0 or {d3..d0}>9999: bcd3..bcd0=9,9,9,9 and ovf=1. Otherwise bcd3..bcd0=d3..d0 and ovf=0.
    - done_tick=1 for exactly the following cycle; state returns to IDLE (ready=1 again in that same cycle).
- Latency: accepting edge E0; iterations on E1..EW; output update, done_tick rise and ready rise on E(W+1). For W=14 that is 15 clocks.
- start while ready=0 is ignored; no queuing. bin changes after E0 have no effect.
- start held high continuously: a new conversion is accepted on the first edge in which state=IDLE, i.e. the edge after done_tick rises. Back-to-back throughput is one result per W+2 clocks.
- bcd3..bcd0 and ovf are stable between done_ticks; never show intermediate working values.
- All digit outputs are always in 0..9.

Test Plan:
- Reset, then bin=0, start pulse → after 15 clks: done_tick pulse, bcd=0,0,0,0, ovf=0; ready high in the done_tick cycle.
- bin=1234, start 1 clk → done_tick exactly 15 edges after the accepting edge; bcd3..0=1,2,3,4. Outputs hold previous value until that edge.
- bin=9999 → 9,9,9,9, ovf=0. Then bin=10000 → 9,9,9,9, ovf=1. Then bin=16383 → 9,9,9,9, ovf=1. Then bin=507 → 0,5,0,7, ovf=0.
- Start conversion of 4321; pulse start with bin=1111 at cycles 3 and 10 → exactly one done_tick, result 4,3,2,1; ready low cycles 1..14.
- start held high, bin=42 → done_tick every 16 clks, bcd=0,0,4,2 each time, never two pulses in adjacent cycles.
- Start conversion of 8765, assert reset asynchronously (mid-cycle) at iteration 7 → outputs 0 and ready=1 immediately, no done_tick. After release, bin=8765 start → 8,7,6,5.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
// Feeds the four-digit seven-segment multiplexer; results are held between
// conversions so the display never shows intermediate working values.
module bin2bcd_seq #(
  parameter int unsigned W = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         ready,
  output logic         done_tick,
  output logic         ovf,
  output logic [3:0]   bcd3,
  output logic [3:0]   bcd2,
  output logic [3:0]   bcd1,
  output logic [3:0]   bcd0
);

  localparam int unsigned DW = 20;              // five working BCD digits
  localparam int unsigned CW = $clog2(W + 1);   // iteration counter width

  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

  state_t          state;
  logic [W-1:0]    sr;
  logic [DW-1:0]   d;
  logic [CW-1:0]   cnt;

  logic [DW-1:0]   d_adj;
  logic [DW+W-1:0] cat_c;
  logic [DW-1:0]   d_next;
  logic [W-1:0]    sr_next;
  logic            ovf_c;

  // Add-3 correction on every working digit that is 5 or more
  always_comb begin
    d_adj = d;
    for (int i = 0; i < 5; i++) begin
      if (d[4*i +: 4] >= 4'd5)
        d_adj[4*i +: 4] = d[4*i +: 4] + 4'd3;
    end
  end

  // One double-dabble step: shift {digits, binary} left, binary MSB into d0
  always_comb begin
    cat_c   = {d_adj, sr} << 1;
    d_next  = cat_c[DW+W-1:W];
    sr_next = cat_c[W-1:0];
  end

  // Values beyond four decimal digits saturate the display at 9999
  always_comb begin
    ovf_c = (d[19:16] != 4'd0) || (d[15:0] > 16'h9999);
  end

  // Control FSM, working registers and registered result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      d         <= '0;
      cnt       <= '0;
      ready     <= 1'b1;
      done_tick <= 1'b0;
      ovf       <= 1'b0;
      bcd3      <= 4'd0;
      bcd2      <= 4'd0;
      bcd1      <= 4'd0;
      bcd0      <= 4'd0;
    end else begin
      done_tick <= 1'b0;
      case (state)
        IDLE: begin
          ready <= 1'b1;
          if (start) begin
            sr    <= bin;
            d     <= '0;
            cnt   <= CW'(W);
            ready <= 1'b0;
            state <= OP;
          end
        end
        OP: begin
          d   <= d_next;
          sr  <= sr_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= DONE;
        end
        DONE: begin
          if (ovf_c) begin
            bcd3 <= 4'd9;
            bcd2 <= 4'd9;
            bcd1 <= 4'd9;
            bcd0 <= 4'd9;
            ovf  <= 1'b1;
          end else begin
            bcd3 <= d[15:12];
            bcd2 <= d[11:8];
            bcd1 <= d[7:4];
            bcd0 <= d[3:0];
            ovf  <= 1'b0;
          end
          done_tick <= 1'b1;
          ready     <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and random checks of bin2bcd_seq against a
// decimal reference model.
module tb_bin2bcd_seq;

  localparam int W = 14;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] bin;
  logic         ready;
  logic         done_tick;
  logic         ovf;
  logic [3:0]   bcd3;
  logic [3:0]   bcd2;
  logic [3:0]   bcd1;
  logic [3:0]   bcd0;
  logic [16:0]  outv;

  int n_assert = 0;
  int n_fail   = 0;

  bin2bcd_seq #(.W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .ready(ready), .done_tick(done_tick), .ovf(ovf),
    .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0)
  );

  assign outv = {ovf, bcd3, bcd2, bcd1, bcd0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, thousands, hundreds, tens, units}, saturating above 9999
  function automatic logic [16:0] ref_model(input int v);
    if (v > 9999) return {1'b1, 16'h9999};
    return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full conversion with latency, hold, result and pulse-width checks
  task automatic conv(input int v);
    logic [16:0] prev;
    logic [16:0] exp;
    int n;
    bit got;
    prev  = outv;
    exp   = ref_model(v);
    bin   = W'(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    bin   = W'($urandom);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (done_tick) got = 1'b1;
      else if (n == W) chk("hold_before_done", 32'(outv), 32'(prev));
    end
    chk("latency", 32'(n), 32'(W + 1));
    chk("result", 32'(outv), 32'(exp));
    chk("ready_at_done", 32'(ready), 32'd1);
    tick();
    chk("done_one_cycle", 32'(done_tick), 32'd0);
  endtask

  initial begin
    int n, ready_bad, pulses, last, gap_bad, val_bad;
    bit got;
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    #12;
    chk("reset_out", 32'(outv), 32'd0);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_done", 32'(done_tick), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    conv(0);
    conv(1234);
    conv(9999);
    conv(10000);
    conv(16383);
    conv(507);

    // Start ignored while busy
    bin = W'(4321);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; got = 1'b0; ready_bad = 0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (done_tick) got = 1'b1;
      else if (ready !== 1'b0) ready_bad++;
      start = (n == 3 || n == 10);
      bin   = (n == 3 || n == 10) ? W'(1111) : W'(4321);
    end
    start = 1'b0;
    chk("busy_latency", 32'(n), 32'(W + 1));
    chk("busy_ready_low", 32'(ready_bad), 32'd0);
    chk("busy_result", 32'(outv), 32'(ref_model(4321)));
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_tick) pulses++;
    end
    chk("busy_single_done", 32'(pulses), 32'd0);

    // Start held high: one result every W+2 clocks
    bin = W'(42);
    start = 1'b1;
    pulses = 0; last = -100; gap_bad = 0; val_bad = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (done_tick) begin
        if (pulses > 0 && (i - last) != W + 2) gap_bad++;
        if (outv !== ref_model(42)) val_bad++;
        pulses++;
        last = i;
      end
    end
    start = 1'b0;
    chk("held_pulses", 32'(pulses), 32'd4);
    chk("held_gap", 32'(gap_bad), 32'd0);
    chk("held_value", 32'(val_bad), 32'd0);
    tick();
    tick();

    // Asynchronous reset in the middle of a conversion
    bin = W'(8765);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #3;
    reset = 1'b1;
    #1;
    chk("abort_out", 32'(outv), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done_tick), 32'd0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done_tick) pulses++;
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_tick) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    conv(8765);

    // Random values across the full input range
    for (int i = 0; i < 25; i++) conv(int'($urandom_range(0, (1 << W) - 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
